// File: rtl/banked_stack_engine.sv
// banked_stack_engine: kernel/user banked stack pointers with PUSH/POP bursts.
// The engine checks capacity once, at accept time, before any memory traffic.
// It then issues one word address per cycle.
// Optional feature macro: STACK_WATERMARK_EN adds per-bank minimum-SP watermarks.
module banked_stack_engine #(
  parameter int ADDR_WIDTH          = 32,
  parameter int KERNEL_STACK_TOP    = 4096,
  parameter int KERNEL_STACK_BOTTOM = 6143,
  parameter int USER_STACK_TOP      = 6144,
  parameter int USER_STACK_BOTTOM   = 8191,
  parameter int MAX_BURST           = 8,
  localparam int CW                 = $clog2(MAX_BURST + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [CW-1:0]         count,
  input  logic                  is_kernel,
  input  logic                  sp_write_en,
  input  logic                  sp_write_kernel,
  input  logic [ADDR_WIDTH-1:0] sp_write_data,
  output logic                  busy,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [CW-1:0]         word_index,
  output logic                  done,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] kernel_sp,
  output logic [ADDR_WIDTH-1:0] user_sp
`ifdef STACK_WATERMARK_EN
  ,
  output logic [ADDR_WIDTH-1:0] kernel_watermark,
  output logic [ADDR_WIDTH-1:0] user_watermark
`endif
);

  localparam logic [ADDR_WIDTH-1:0] K_TOP   = ADDR_WIDTH'(KERNEL_STACK_TOP);
  localparam logic [ADDR_WIDTH-1:0] U_TOP   = ADDR_WIDTH'(USER_STACK_TOP);
  localparam logic [ADDR_WIDTH-1:0] K_EMPTY = ADDR_WIDTH'(KERNEL_STACK_BOTTOM + 1);
  localparam logic [ADDR_WIDTH-1:0] U_EMPTY = ADDR_WIDTH'(USER_STACK_BOTTOM + 1);
  localparam logic [CW-1:0]         MAX_CNT = CW'(MAX_BURST);
  localparam logic [1:0]            OP_PUSH = 2'b01;
  localparam logic [1:0]            OP_POP  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, FINISH = 2'd2} state_t;

  state_t                  state_r;
  logic                    push_r;
  logic                    bank_r;
  logic [CW-1:0]           count_r;
  logic                    busy_r, mem_valid_r, mem_write_r, done_r, fault_r;
  logic [ADDR_WIDTH-1:0]   mem_address_r;
  logic [CW-1:0]           word_index_r;
  logic [ADDR_WIDTH-1:0]   kernel_sp_r, user_sp_r;

  logic [ADDR_WIDTH-1:0]   sel_sp_s, sel_top_s, sel_empty_s, cnt_ext_s;
  logic [ADDR_WIDTH:0]     pop_sum_s;
  logic                    reject_s;
  logic [ADDR_WIDTH-1:0]   cur_sp_s, next_sp_s;

  // Capacity check for a request presented in IDLE (uses live inputs).
  always_comb begin
    sel_sp_s    = is_kernel ? kernel_sp_r : user_sp_r;
    sel_top_s   = is_kernel ? K_TOP : U_TOP;
    sel_empty_s = is_kernel ? K_EMPTY : U_EMPTY;
    cnt_ext_s   = ADDR_WIDTH'(count);
    // One extra bit so a POP near the top of the address space cannot wrap.
    pop_sum_s   = {1'b0, sel_sp_s} + {1'b0, cnt_ext_s};
    reject_s    = 1'b0;
    if ((op != OP_PUSH) && (op != OP_POP)) begin
      reject_s = 1'b1;
    end else if (count > MAX_CNT) begin
      reject_s = 1'b1;
    end else if (op == OP_PUSH) begin
      reject_s = (cnt_ext_s > sel_sp_s) || ((sel_sp_s - cnt_ext_s) < sel_top_s);
    end else begin
      reject_s = (pop_sum_s > {1'b0, sel_empty_s});
    end
  end

  // SP step for the word being issued this cycle in BURST.
  always_comb begin
    cur_sp_s = bank_r ? kernel_sp_r : user_sp_r;
    if (push_r) begin
      next_sp_s = cur_sp_s - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      next_sp_s = cur_sp_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM with registered outputs and the two bank stack pointers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= IDLE;
      push_r        <= 1'b0;
      bank_r        <= 1'b0;
      count_r       <= '0;
      busy_r        <= 1'b0;
      mem_valid_r   <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_address_r <= '0;
      word_index_r  <= '0;
      done_r        <= 1'b0;
      fault_r       <= 1'b0;
      kernel_sp_r   <= K_EMPTY;
      user_sp_r     <= U_EMPTY;
    end else begin
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          fault_r <= 1'b0;
          if (sp_write_en) begin
            // An SP load wins over a start in the same cycle.
            if (sp_write_kernel) kernel_sp_r <= sp_write_data;
            else                 user_sp_r   <= sp_write_data;
          end else if (start) begin
            push_r       <= (op == OP_PUSH);
            bank_r       <= is_kernel;
            count_r      <= count;
            busy_r       <= 1'b1;
            word_index_r <= '0;
            if (reject_s) begin
              fault_r <= 1'b1;
              done_r  <= 1'b1;
              state_r <= FINISH;
            end else if (count == {CW{1'b0}}) begin
              done_r  <= 1'b1;
              state_r <= FINISH;
            end else begin
              // First word goes out in the cycle right after accept.
              mem_valid_r   <= 1'b1;
              mem_write_r   <= (op == OP_PUSH);
              mem_address_r <= (op == OP_PUSH) ?
                               (sel_sp_s - {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) : sel_sp_s;
              state_r       <= BURST;
            end
          end
        end
        BURST: begin
          if (bank_r) kernel_sp_r <= next_sp_s;
          else        user_sp_r   <= next_sp_s;
          if (word_index_r == (count_r - {{(CW-1){1'b0}}, 1'b1})) begin
            mem_valid_r   <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_address_r <= '0;
            word_index_r  <= '0;
            done_r        <= 1'b1;
            state_r       <= FINISH;
          end else begin
            word_index_r  <= word_index_r + {{(CW-1){1'b0}}, 1'b1};
            mem_address_r <= push_r ?
                             (next_sp_s - {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) : next_sp_s;
          end
        end
        FINISH: begin
          done_r  <= 1'b0;
          fault_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          mem_valid_r <= 1'b0;
          done_r      <= 1'b0;
          fault_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef STACK_WATERMARK_EN
  logic [ADDR_WIDTH-1:0] kernel_wm_r, user_wm_r;

  // Track the lowest SP each bank has ever held; POP never raises it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      kernel_wm_r <= K_EMPTY;
      user_wm_r   <= U_EMPTY;
    end else if ((state_r == IDLE) && sp_write_en) begin
      if (sp_write_kernel) begin
        if (sp_write_data < kernel_wm_r) kernel_wm_r <= sp_write_data;
      end else begin
        if (sp_write_data < user_wm_r) user_wm_r <= sp_write_data;
      end
    end else if ((state_r == BURST) && push_r) begin
      if (bank_r) begin
        if (next_sp_s < kernel_wm_r) kernel_wm_r <= next_sp_s;
      end else begin
        if (next_sp_s < user_wm_r) user_wm_r <= next_sp_s;
      end
    end
  end

  assign kernel_watermark = kernel_wm_r;
  assign user_watermark   = user_wm_r;
`endif

  assign busy        = busy_r;
  assign mem_valid   = mem_valid_r;
  assign mem_write   = mem_write_r;
  assign mem_address = mem_address_r;
  assign word_index  = word_index_r;
  assign done        = done_r;
  assign fault       = fault_r;
  assign kernel_sp   = kernel_sp_r;
  assign user_sp     = user_sp_r;

endmodule

// File: tb/tb_banked_stack_engine.sv
// Directed self-checking bench for banked_stack_engine (default parameters).
module tb_banked_stack_engine;

  localparam int AW = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [CW-1:0] count = '0;
  logic          is_kernel = 1'b0;
  logic          sp_write_en = 1'b0;
  logic          sp_write_kernel = 1'b0;
  logic [AW-1:0] sp_write_data = '0;
  logic          busy, mem_valid, mem_write, done, fault;
  logic [AW-1:0] mem_address, kernel_sp, user_sp;
  logic [CW-1:0] word_index;
`ifdef STACK_WATERMARK_EN
  logic [AW-1:0] kernel_watermark, user_watermark;
`endif

  int n_vec = 0;
  int n_err = 0;

  banked_stack_engine dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .count(count),
    .is_kernel(is_kernel), .sp_write_en(sp_write_en),
    .sp_write_kernel(sp_write_kernel), .sp_write_data(sp_write_data),
    .busy(busy), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_address(mem_address), .word_index(word_index), .done(done),
    .fault(fault), .kernel_sp(kernel_sp), .user_sp(user_sp)
`ifdef STACK_WATERMARK_EN
    , .kernel_watermark(kernel_watermark), .user_watermark(user_watermark)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request and walk it to IDLE, checking each cycle against hand values.
  task automatic do_burst(input string tag, input logic [1:0] o, input int n,
                          input logic k, input int sp0, input logic exp_fault,
                          input logic hold_junk);
    int  words;
    logic push;
    int  exp_sp;
    push = (o == 2'b01);
    start = 1'b1; op = o; count = CW'(n); is_kernel = k;
    tick();
    start = 1'b0; op = 2'b00; count = '0;
    words = exp_fault ? 0 : n;
    for (int i = 0; i < words; i++) begin
      if (hold_junk) begin
        start = 1'b1; op = 2'b10; count = CW'(1); is_kernel = ~k;
        sp_write_en = 1'b1; sp_write_kernel = k; sp_write_data = '0;
      end
      check_eq({tag, "_valid"}, 32'(mem_valid), 32'd1);
      check_eq({tag, "_write"}, 32'(mem_write), 32'(push));
      check_eq({tag, "_addr"}, mem_address, push ? 32'(sp0 - 1 - i) : 32'(sp0 + i));
      check_eq({tag, "_idx"}, 32'(word_index), 32'(i));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_early_done"}, 32'(done), 32'd0);
      check_eq({tag, "_sp_step"}, k ? kernel_sp : user_sp,
               push ? 32'(sp0 - i) : 32'(sp0 + i));
      tick();
    end
    start = 1'b0; op = 2'b00; count = '0; is_kernel = k;
    sp_write_en = 1'b0; sp_write_data = '0;
    exp_sp = exp_fault ? sp0 : (push ? sp0 - n : sp0 + n);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_fault"}, 32'(fault), 32'(exp_fault));
    check_eq({tag, "_no_valid"}, 32'(mem_valid), 32'd0);
    check_eq({tag, "_sp_end"}, k ? kernel_sp : user_sp, 32'(exp_sp));
    tick();
    check_eq({tag, "_idle_done"}, 32'(done), 32'd0);
    check_eq({tag, "_idle_fault"}, 32'(fault), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    tick(); tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_write", 32'(mem_write), 32'd0);
    check_eq("rst_addr", mem_address, 32'd0);
    check_eq("rst_idx", 32'(word_index), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_ksp", kernel_sp, 32'd6144);
    check_eq("rst_usp", user_sp, 32'd8192);
`ifdef STACK_WATERMARK_EN
    check_eq("rst_kwm", kernel_watermark, 32'd6144);
    check_eq("rst_uwm", user_watermark, 32'd8192);
`endif
    reset = 1'b1;
    tick();

    // User POP on an empty stack underflows
    do_burst("upop_empty", 2'b10, 1, 1'b0, 8192, 1'b1, 1'b0);

    // Kernel PUSH 3 then POP 2
    do_burst("kpush3", 2'b01, 3, 1'b1, 6144, 1'b0, 1'b0);
    check_eq("kpush3_usp", user_sp, 32'd8192);
    do_burst("kpop2", 2'b10, 2, 1'b1, 6141, 1'b0, 1'b0);
    check_eq("kpop2_ksp", kernel_sp, 32'd6143);
`ifdef STACK_WATERMARK_EN
    check_eq("kpop2_kwm", kernel_watermark, 32'd6141);
`endif

    // sp_write together with start: SP loaded, start ignored
    sp_write_en = 1'b1; sp_write_kernel = 1'b1; sp_write_data = 32'd4098;
    start = 1'b1; op = 2'b01; count = CW'(1); is_kernel = 1'b1;
    tick();
    sp_write_en = 1'b0; start = 1'b0; op = 2'b00; count = '0;
    check_eq("spw_ksp", kernel_sp, 32'd4098);
    check_eq("spw_busy", 32'(busy), 32'd0);
    check_eq("spw_valid", 32'(mem_valid), 32'd0);
    tick();
    check_eq("spw_no_done", 32'(done), 32'd0);
    check_eq("spw_busy2", 32'(busy), 32'd0);
`ifdef STACK_WATERMARK_EN
    check_eq("spw_kwm", kernel_watermark, 32'd4098);
`endif

    // Fill to TOP exactly, then overflow by one
    do_burst("kpush_top", 2'b01, 2, 1'b1, 4098, 1'b0, 1'b0);
    do_burst("kpush_over", 2'b01, 1, 1'b1, 4096, 1'b1, 1'b0);
`ifdef STACK_WATERMARK_EN
    check_eq("top_kwm", kernel_watermark, 32'd4096);
`endif

    // Illegal ops, oversized count, empty burst
    do_burst("op11", 2'b11, 1, 1'b0, 8192, 1'b1, 1'b0);
    do_burst("op00", 2'b00, 1, 1'b0, 8192, 1'b1, 1'b0);
    do_burst("cnt9", 2'b10, 9, 1'b0, 8192, 1'b1, 1'b0);
    do_burst("cnt0", 2'b01, 0, 1'b1, 4096, 1'b0, 1'b0);

    // Inputs toggling during a burst are ignored; then a back-to-back POP
    do_burst("upush_hold", 2'b01, 2, 1'b0, 8192, 1'b0, 1'b1);
    check_eq("hold_ksp", kernel_sp, 32'd4096);
`ifdef STACK_WATERMARK_EN
    check_eq("hold_uwm", user_watermark, 32'd8190);
`endif
    do_burst("upop_b2b", 2'b10, 2, 1'b0, 8190, 1'b0, 1'b0);

    // Reset in the middle of a user PUSH 5
    start = 1'b1; op = 2'b01; count = CW'(5); is_kernel = 1'b0;
    tick();
    start = 1'b0; op = 2'b00; count = '0;
    check_eq("mid_addr0", mem_address, 32'd8191);
    tick(); tick();
    check_eq("mid_usp", user_sp, 32'd8190);
    check_eq("mid_ksp", kernel_sp, 32'd4096);
    reset = 1'b0;
    tick();
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_fault", 32'(fault), 32'd0);
    check_eq("mid_rst_valid", 32'(mem_valid), 32'd0);
    check_eq("mid_rst_ksp", kernel_sp, 32'd6144);
    check_eq("mid_rst_usp", user_sp, 32'd8192);
`ifdef STACK_WATERMARK_EN
    check_eq("mid_rst_kwm", kernel_watermark, 32'd6144);
`endif
    reset = 1'b1;
    tick();
    check_eq("post_rst_done", 32'(done), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
